// File: rtl/xadc_frame_sequencer_pkg.sv
// rtl/xadc_frame_sequencer_pkg.sv - shared FSM encoding, XADC DRP constants and sample conversion
package xadc_frame_sequencer_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_READ     = 2'd1;
    localparam logic [1:0] ST_WAIT_RDY = 2'd2;
    localparam logic [1:0] ST_SEND     = 2'd3;

    localparam logic [6:0] DRP_ADDR_VAUX0 = 7'h10;

    localparam int DEFAULT_FRAME_LEN = 1024;

    // Unipolar 12-bit XADC code (left-justified in do[15:4]) to signed 16-bit.
    // Flipping the MSB moves midscale to zero. The arithmetic shift then
    // sign-extends and discards the four unused LSBs.
    function automatic logic [15:0] xadc_to_s16(input logic [15:0] d);
        logic signed [15:0] flipped;
        flipped = {~d[15], d[14:0]};
        return flipped >>> 4;
    endfunction

endpackage

// File: rtl/xadc_frame_sequencer_timeout.sv
// rtl/xadc_frame_sequencer_timeout.sv - drp_timeout_ctr: WAIT_RDY cycle counter with expire flag
//
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   load        : restart the count (asserted in the cycle before the wait)
//   count       : one wait cycle elapsed without data
//   expire      : high in the TIMEOUT-th counted cycle
module drp_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expire = count && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (count && !expire) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/xadc_frame_sequencer.sv
// rtl/xadc_frame_sequencer.sv - XADC DRP sample reader feeding an AXI-Stream FFT frame
//
// Ports:
//   CLK, resetn              : clock, asynchronous active-low reset (release synchronised)
//   enable                   : capture enable, sampled in IDLE
//   eoc_in, channel_in       : XADC end-of-conversion pulse and its channel
//   den_out, daddr_out, dwe_out, drdy_in, do_in : DRP read port
//   m_axis_t*                : sample stream, tlast on the last sample of each frame
//   clear_err                : clear sticky flags
//   overrun, timeout_err     : sticky error flags
module xadc_frame_sequencer
    import xadc_frame_sequencer_pkg::*;
#(
    parameter int         FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter logic [4:0] CHAN      = DRP_ADDR_VAUX0[4:0],
    parameter int         TIMEOUT   = 15
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        enable,
    input  logic        eoc_in,
    input  logic [4:0]  channel_in,
    output logic        den_out,
    output logic [6:0]  daddr_out,
    output logic        dwe_out,
    input  logic        drdy_in,
    input  logic [15:0] do_in,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tlast,
    input  logic        clear_err,
    output logic        overrun,
    output logic        timeout_err
);

    localparam int FIDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [1:0]        rst_sync;
    logic              run;
    logic [1:0]        state;
    logic [FIDX_W-1:0] frame_idx;
    logic              chan_eoc;
    logic              tmo_expire;
    logic              tmo_fire;

    assign dwe_out  = 1'b0;
    assign chan_eoc = eoc_in && (channel_in == CHAN);
    // A drdy in the last wait cycle still counts as a response.
    assign tmo_fire = tmo_expire && !drdy_in;

    // Reset asserts immediately. The FSM may leave IDLE only two edges
    // after release, so that all flops come out of reset together.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign run = rst_sync[1];

    drp_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (CLK),
        .resetn  (resetn),
        .load    (state == ST_READ),
        .count   (state == ST_WAIT_RDY),
        .expire  (tmo_expire)
    );

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            den_out       <= 1'b0;
            daddr_out     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            frame_idx     <= '0;
        end else begin
            den_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!enable) begin
                        frame_idx <= '0;
                    end
                    if (run && enable && chan_eoc) begin
                        state     <= ST_READ;
                        den_out   <= 1'b1;
                        daddr_out <= {2'b00, CHAN};
                    end
                end
                ST_READ: begin
                    state <= ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (drdy_in) begin
                        m_axis_tdata  <= xadc_to_s16(do_in);
                        m_axis_tlast  <= (frame_idx == FIDX_W'(FRAME_LEN - 1));
                        m_axis_tvalid <= 1'b1;
                        state         <= ST_SEND;
                    end else if (tmo_fire) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        frame_idx     <= frame_idx + FIDX_W'(1);
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as clear_err wins.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (chan_eoc && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
            if (tmo_fire) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/xadc_frame_sequencer.md
XADC_FRAME_SEQUENCER -- requirements
Module: xadc_frame_sequencer

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 1024, meaning samples per FFT frame (power of two, 2..4096).
REQ-002 The block SHALL have parameter CHAN, default 5'h10, meaning the XADC channel (VAUX0) accepted for capture.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, meaning max cycles waited for drdy after den.
REQ-004 CLK  input  1  system clock; all logic is rising-edge.
REQ-005 resetn  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
REQ-006 enable  input  1  capture enable, level.
REQ-007 eoc_in  input  1  XADC end-of-conversion pulse.
REQ-008 channel_in  input  5  XADC channel of the completed conversion.
REQ-009 den_out  output  1  DRP enable, single-cycle pulse.
REQ-010 daddr_out  output  7  DRP address.
REQ-011 dwe_out  output  1  DRP write enable; tied 0.
REQ-012 drdy_in  input  1  DRP read data valid.
REQ-013 do_in  input  16  DRP read data.
REQ-014 m_axis_tvalid / m_axis_tready / m_axis_tdata[15:0] / m_axis_tlast  out/in/out/out  AXI-Stream sample output to FFT.
REQ-015 clear_err  input  1  synchronous clear of sticky error flags.
REQ-016 overrun  output  1  sticky: eoc dropped.
REQ-017 timeout_err  output  1  sticky: drdy not received within TIMEOUT.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WAIT_RDY, SEND.
REQ-019 IDLE->READ SHALL occur when enable=1, eoc_in=1 and channel_in==CHAN; otherwise IDLE holds.
REQ-020 READ SHALL assert den_out for exactly one cycle with daddr_out={2'b00,CHAN}, then go to WAIT_RDY; den_out rises the cycle after eoc_in.
REQ-021 WAIT_RDY SHALL capture do_in on drdy_in=1 and go to SEND; after TIMEOUT cycles without drdy_in it SHALL set timeout_err and return to IDLE with no sample emitted.
REQ-022 Sample format: m_axis_tdata = sign-extend to 16 bits of {~do_in[15], do_in[14:4]} (unipolar 12-bit to two's complement, midscale -> 0).
REQ-023 SEND SHALL assert m_axis_tvalid the cycle after drdy_in, hold tdata/tlast stable until m_axis_tready=1, then return to IDLE.
REQ-024 m_axis_tlast SHALL be 1 on the sample with frame index FRAME_LEN-1; frame index increments on each accepted transfer and wraps to 0.
REQ-025 An eoc_in with channel_in==CHAN arriving in READ, WAIT_RDY or SEND SHALL set overrun and be discarded; eoc_in on the IDLE->READ cycle is not an overrun.
REQ-026 drdy_in in any state other than WAIT_RDY SHALL be ignored.
REQ-027 enable is sampled only in IDLE; deassertion mid-transaction completes the current sample; on IDLE with enable=0 the frame index SHALL reset to 0.
REQ-028 clear_err=1 SHALL clear overrun and timeout_err; a simultaneous set event SHALL win.
REQ-029 Minimum throughput: one sample per 4 cycles with tready=1 and immediate drdy.

Reset
REQ-030 resetn=0 SHALL asynchronously force: state IDLE, den_out=0, daddr_out=0, dwe_out=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, frame index 0, timeout counter 0, overrun=0, timeout_err=0.
REQ-031 Reset release SHALL be synchronised internally (2-flop deassertion) before the FSM leaves IDLE; reset mid-transaction discards the in-flight sample.

Structure
REQ-032 A shared package/include SHALL hold the FSM state encoding, XADC DRP address constants (VAUX0=7'h10) and default FRAME_LEN.
REQ-033 One sub-module, drp_timeout_ctr (load/count/expire), SHALL implement the WAIT_RDY timeout; all else is inline.

Verification
REQ-034 eoc_in with channel 5'h10, drdy 2 cycles after den, do_in=16'hFFF0, tready=1 -> den one cycle, tdata=16'h07FF, tvalid one cycle.
REQ-035 do_in=16'h8000 -> tdata=16'h0000; do_in=16'h0000 -> tdata=16'hF800.
REQ-036 FRAME_LEN=8, 20 back-to-back samples -> tlast on samples 8 and 16 only.
REQ-037 tready held 0 for 10 cycles while a second eoc arrives -> tdata stable, overrun=1 set, only one sample emitted; clear_err -> overrun=0.
REQ-038 No drdy after den -> timeout_err=1 at TIMEOUT cycles, FSM IDLE, no tvalid; next eoc processed normally.
REQ-039 resetn pulsed low during WAIT_RDY -> all outputs 0 immediately, late drdy ignored, frame index 0 afterwards.
